// File: rtl/envelope_pkg.sv
// envelope_pkg
// Shared constants and types for the envelope follower:
//   - gate FSM state encoding (2 bits)
//   - level width (8) and stepping accumulator width (9, carry in the MSB)
//   - rectify slice constants and the rectify helper
package envelope_pkg;

    localparam int SAMPLE_W = 16;
    localparam int LEVEL_W  = 8;
    localparam int ACC_W    = 9;
    localparam int RECT_MSB = 14;
    localparam int RECT_LSB = 7;

    typedef enum logic [1:0] {
        GATE_OFF  = 2'd0,
        GATE_ON   = 2'd1,
        GATE_HOLD = 2'd2
    } gate_state_e;

    // Magnitude of a signed sample, with -32768 saturated to 32767 so the
    // result always fits in 15 bits; the top 8 of those bits are the target.
    function automatic logic [LEVEL_W-1:0] rectify(input logic [SAMPLE_W-1:0] s);
        logic [SAMPLE_W-1:0] mag;
        if (s[SAMPLE_W-1]) begin
            if (s == 16'h8000) begin
                mag = 16'h7FFF;
            end else begin
                mag = ~s + 16'd1;
            end
        end else begin
            mag = s;
        end
        return mag[RECT_MSB:RECT_LSB];
    endfunction

endpackage

// File: rtl/envelope_follower_rate_stepper.sv
// rate_stepper
// Fractional rate stepper: on each strobe with a direction request, adds the
// rate to an 8-bit accumulator; the carry out becomes a one-level step.
// The accumulator restarts from 0 whenever the direction request differs
// from the previous strobe's (including "no movement").
// Ports:
//   clk, rst_n  clock, async active-low reset
//   rate        8-bit step rate (0 = frozen, 255 = fastest)
//   up, down    direction request for this strobe (mutually exclusive)
//   strobe      sample strobe; state only changes when high
//   step        combinational: move level by one this strobe
module rate_stepper
    import envelope_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LEVEL_W-1:0] rate,
    input  logic               up,
    input  logic               down,
    input  logic               strobe,
    output logic               step
);

    logic [LEVEL_W-1:0] acc_q, acc_d;
    logic [1:0]         dir_q, dir_d;
    logic [1:0]         dir_now;
    logic [LEVEL_W-1:0] acc_base;
    logic [ACC_W-1:0]   sum;

    always_comb begin
        dir_now  = {up, down};
        acc_base = (dir_now == dir_q) ? acc_q : '0;
        sum      = {1'b0, acc_base} + {1'b0, rate};
        acc_d    = acc_q;
        dir_d    = dir_q;
        step     = 1'b0;
        if (strobe) begin
            if (up ^ down) begin
                acc_d = sum[LEVEL_W-1:0];
                dir_d = dir_now;
                step  = sum[ACC_W-1];
            end else begin
                acc_d = '0;
                dir_d = 2'b00;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            dir_q <= 2'b00;
        end else begin
            acc_q <= acc_d;
            dir_q <= dir_d;
        end
    end

endmodule

// File: rtl/envelope_follower.sv
// envelope_follower
// Tracks the rectified amplitude of a strobed audio stream with separate
// attack/release rates, and derives a hysteretic gate with a hold-off count.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sample_strobe  one-clk pulse qualifying sample_in
//   sample_in      signed 16-bit sample
//   attack         rise rate (0 freezes rise)
//   release_rate   fall rate (0 freezes fall)
//   thr_on         gate-on threshold
//   thr_off        gate-off threshold (effective value is min(thr_off, thr_on))
//   hold           strobes below the off threshold tolerated before gate drops
//   level          registered envelope level
//   gate           registered gate
//   level_valid    one-clk pulse one clk after each strobe
//
// state     | meaning
// GATE_OFF  | gate low, waiting for level >= thr_on
// GATE_ON   | gate high, level at or above the off threshold
// GATE_HOLD | gate high, level below the off threshold, counting strobes
module envelope_follower
    import envelope_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_strobe,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [LEVEL_W-1:0]  attack,
    input  logic [LEVEL_W-1:0]  release_rate,
    input  logic [LEVEL_W-1:0]  thr_on,
    input  logic [LEVEL_W-1:0]  thr_off,
    input  logic [LEVEL_W-1:0]  hold,
    output logic [LEVEL_W-1:0]  level,
    output logic                gate,
    output logic                level_valid
);

    gate_state_e        state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [LEVEL_W-1:0] cnt_q, cnt_d;
    logic               gate_q, gate_d;
    logic               level_valid_q, level_valid_d;

    logic [LEVEL_W-1:0] target;
    logic [LEVEL_W-1:0] off_thr;
    logic [LEVEL_W-1:0] rate;
    logic               up, down, step;

    // Level only moves one count per strobe, and only toward the target,
    // so it can neither overshoot nor wrap.
    always_comb begin
        target = rectify(sample_in);
        up     = (target > level_q);
        down   = (target < level_q);
        rate   = up ? attack : release_rate;
    end

    rate_stepper u_rate_stepper (
        .clk    (clk),
        .rst_n  (rst_n),
        .rate   (rate),
        .up     (up),
        .down   (down),
        .strobe (sample_strobe),
        .step   (step)
    );

    always_comb begin
        level_d = level_q;
        if (sample_strobe && step) begin
            if (up) begin
                level_d = level_q + 8'd1;
            end else begin
                level_d = level_q - 8'd1;
            end
        end
        level_valid_d = sample_strobe;
    end

    // Gate decisions use the level as it stood before this strobe's update.
    always_comb begin
        off_thr = (thr_off < thr_on) ? thr_off : thr_on;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sample_strobe) begin
            case (state_q)
                GATE_OFF: begin
                    if (level_q >= thr_on) begin
                        state_d = GATE_ON;
                    end
                end
                GATE_ON: begin
                    if (level_q < off_thr) begin
                        state_d = GATE_HOLD;
                        cnt_d   = '0;
                    end
                end
                GATE_HOLD: begin
                    if (level_q >= thr_on) begin
                        state_d = GATE_ON;
                    end else if (level_q >= off_thr) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                        // >= also covers hold=0 and hold lowered mid-count
                        if (cnt_d >= hold) begin
                            state_d = GATE_OFF;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = GATE_OFF;
                    cnt_d   = '0;
                end
            endcase
        end
        gate_d = (state_d != GATE_OFF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= GATE_OFF;
            level_q       <= '0;
            cnt_q         <= '0;
            gate_q        <= 1'b0;
            level_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            gate_q        <= gate_d;
            level_valid_q <= level_valid_d;
        end
    end

    assign level       = level_q;
    assign gate        = gate_q;
    assign level_valid = level_valid_q;

endmodule
